// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the divided-clock frequency/lock monitor.
package clk_div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      MEASURE,
      LOCKED,
      FAULT
   } mon_state_t;

   localparam int LOCK_COUNT_DEF = 4;

   // Divider ratio code d yields a full period of 2^(d+1) source cycles.
   function automatic int unsigned exp_period(input int unsigned div_ctrl);
      return 32'd2 << div_ctrl;
   endfunction

endpackage

// File: rtl/clk_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_in domain.
module clk_sync2 (
   input  logic clk_in,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the divided clock period in source cycles and tracks lock/fault.
module clk_div_monitor
   import clk_div_pkg::*;
#(
   parameter int DIV_WIDTH    = 2,
   parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
   parameter int PERIOD_WIDTH = 2**DIV_WIDTH + 2
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    clk_div_in,
   input  logic [DIV_WIDTH-1:0]    div_ctrl,
   input  logic                    enable,
   input  logic                    fault_clr,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid,
   output logic                    locked,
   output logic                    fault
);

   localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [3:0]              LOCK_N  = 4'(LOCK_COUNT);

   mon_state_t state_q, state_d;

   logic                    s2;
   logic                    s3_q;
   logic                    rise;
   logic                    div_chg;
   logic [DIV_WIDTH-1:0]    div_ctrl_q;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [PERIOD_WIDTH-1:0] cnt_inc;
   logic [PERIOD_WIDTH-1:0] per_q, per_d;
   logic [PERIOD_WIDTH-1:0] exp_w;
   logic [PERIOD_WIDTH-1:0] tmo_w;
   logic [3:0]              match_q, match_d;
   logic                    pv_q, pv_d;

   clk_sync2 u_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d_i    (clk_div_in),
      .q_o    (s2)
   );

   assign rise    = s2 & ~s3_q;
   assign div_chg = div_ctrl != div_ctrl_q;
   assign exp_w   = PERIOD_WIDTH'(exp_period(32'(div_ctrl)));
   assign tmo_w   = {exp_w[PERIOD_WIDTH-2:0], 1'b1};

   // Saturating increment doubles as the candidate period value.
   assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX
                                       : cnt_q + PERIOD_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      match_d = match_q;
      per_d   = per_q;
      pv_d    = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         match_d = '0;
         per_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ARM;
               cnt_d   = '0;
            end
            ARM: begin
               if (div_chg) begin
                  cnt_d   = '0;
                  match_d = '0;
               end else if (rise) begin
                  state_d = MEASURE;
                  cnt_d   = '0;
                  match_d = '0;
               end
            end
            MEASURE: begin
               if (div_chg) begin
                  state_d = ARM;
                  cnt_d   = '0;
                  match_d = '0;
               end else if (rise) begin
                  pv_d  = 1'b1;
                  per_d = cnt_inc;
                  cnt_d = '0;
                  if (cnt_inc == exp_w) begin
                     match_d = match_q + 4'd1;
                     if (match_d == LOCK_N) state_d = LOCKED;
                  end else begin
                     match_d = '0;
                  end
               end else if (cnt_inc == tmo_w) begin
                  state_d = ARM;
                  match_d = '0;
               end
            end
            LOCKED: begin
               if (div_chg) begin
                  state_d = ARM;
                  cnt_d   = '0;
                  match_d = '0;
               end else if (rise) begin
                  pv_d  = 1'b1;
                  per_d = cnt_inc;
                  cnt_d = '0;
                  if (cnt_inc != exp_w) state_d = FAULT;
               end else if (cnt_inc == tmo_w) begin
                  state_d = FAULT;
               end
            end
            FAULT: begin
               // A ratio change only masks the rise; the fault stays sticky.
               if (div_chg) begin
                  state_d = FAULT;
               end else if (fault_clr) begin
                  state_d = ARM;
                  match_d = '0;
               end else if (rise) begin
                  pv_d  = 1'b1;
                  per_d = cnt_inc;
                  cnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         s3_q       <= 1'b0;
         div_ctrl_q <= '0;
         cnt_q      <= '0;
         match_q    <= '0;
         per_q      <= '0;
         pv_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         s3_q       <= s2;
         div_ctrl_q <= div_ctrl;
         cnt_q      <= cnt_d;
         match_q    <= match_d;
         per_q      <= per_d;
         pv_q       <= pv_d;
      end
   end

   assign period       = per_q;
   assign period_valid = pv_q;
   assign locked       = state_q == LOCKED;
   assign fault        = state_q == FAULT;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized and directed check of clk_div_monitor against a timestamp model.
module tb_clk_div_monitor;

   localparam int DW    = 2;
   localparam int PW    = 2**DW + 2;
   localparam int LOCKN = 4;
   localparam int MAXP  = 2**PW - 1;

   localparam int S_IDLE = 0;
   localparam int S_ARM  = 1;
   localparam int S_MEAS = 2;
   localparam int S_LOCK = 3;
   localparam int S_FLT  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_div_in = 1'b0;
   logic [DW-1:0] div_ctrl = '0;
   logic          enable = 1'b0;
   logic          fault_clr = 1'b0;
   logic [PW-1:0] period;
   logic          pv;
   logic          locked;
   logic          fault;

   int n_chk  = 0;
   int n_fail = 0;

   clk_div_monitor #(
      .DIV_WIDTH    (DW),
      .LOCK_COUNT   (LOCKN),
      .PERIOD_WIDTH (PW)
   ) dut (
      .clk_in       (clk),
      .rst          (rst),
      .clk_div_in   (clk_div_in),
      .div_ctrl     (div_ctrl),
      .enable       (enable),
      .fault_clr    (fault_clr),
      .period       (period),
      .period_valid (pv),
      .locked       (locked),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, req, $time);
      end
   endfunction

   // Divided-clock source: ideal divider, fixed half period, stopped, noise.
   int gmode = 0;
   int ghalf = 3;
   int gcnt  = 0;

   always @(negedge clk) begin
      case (gmode)
         0: begin
            gcnt++;
            if (gcnt >= (1 << div_ctrl)) begin
               gcnt = 0;
               clk_div_in = ~clk_div_in;
            end
         end
         1: begin
            gcnt++;
            if (gcnt >= ghalf) begin
               gcnt = 0;
               clk_div_in = ~clk_div_in;
            end
         end
         2: clk_div_in = 1'b0;
         default: if ($urandom_range(0, 3) == 0) clk_div_in = ~clk_div_in;
      endcase
   end

   // Model: a sample history gives the rise, a timestamp gives the period.
   int cyc    = 0;
   int refc   = 0;
   bit h[4]   = '{default: 1'b0};
   int m_st   = S_IDLE;
   int m_mt   = 0;
   int m_per  = 0;
   bit m_pv   = 1'b0;
   int dc_prv = 0;
   int el, ev, tm;
   bit rz, chg;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         refc   = cyc;
         h      = '{default: 1'b0};
         m_st   = S_IDLE;
         m_mt   = 0;
         m_per  = 0;
         m_pv   = 1'b0;
         dc_prv = 0;
      end else begin
         cyc++;
         h[3] = h[2];
         h[2] = h[1];
         h[1] = h[0];
         h[0] = clk_div_in;
         rz   = h[2] & ~h[3];
         el   = cyc - refc;
         if (el > MAXP) el = MAXP;
         ev   = 2 << div_ctrl;
         tm   = 2 * ev + 1;
         chg  = int'(div_ctrl) != dc_prv;
         dc_prv = int'(div_ctrl);
         m_pv = 1'b0;
         if (!enable) begin
            m_st  = S_IDLE;
            m_per = 0;
            m_mt  = 0;
            refc  = cyc;
         end else begin
            case (m_st)
               S_IDLE: begin
                  m_st = S_ARM;
                  refc = cyc;
               end
               S_ARM: begin
                  if (chg) begin
                     refc = cyc;
                  end else if (rz) begin
                     refc = cyc;
                     m_st = S_MEAS;
                     m_mt = 0;
                  end
               end
               S_MEAS: begin
                  if (chg) begin
                     refc = cyc;
                     m_st = S_ARM;
                     m_mt = 0;
                  end else if (rz) begin
                     m_pv  = 1'b1;
                     m_per = el;
                     refc  = cyc;
                     if (el == ev) begin
                        m_mt++;
                        if (m_mt == LOCKN) m_st = S_LOCK;
                     end else begin
                        m_mt = 0;
                     end
                  end else if (el == tm) begin
                     m_st = S_ARM;
                     m_mt = 0;
                  end
               end
               S_LOCK: begin
                  if (chg) begin
                     refc = cyc;
                     m_st = S_ARM;
                     m_mt = 0;
                  end else if (rz) begin
                     m_pv  = 1'b1;
                     m_per = el;
                     refc  = cyc;
                     if (el != ev) m_st = S_FLT;
                  end else if (el == tm) begin
                     m_st = S_FLT;
                  end
               end
               default: begin
                  if (chg) begin
                     m_st = S_FLT;
                  end else if (fault_clr) begin
                     m_st = S_ARM;
                     m_mt = 0;
                  end else if (rz) begin
                     m_pv  = 1'b1;
                     m_per = el;
                     refc  = cyc;
                  end
               end
            endcase
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("period", int'(period), m_per);
      chk("period_valid", int'(pv), int'(m_pv));
      chk("locked", int'(locked), int'(m_st == S_LOCK));
      chk("fault", int'(fault), int'(m_st == S_FLT));
   end

   task automatic wait_locked(input int maxc, input string nm,
                              output int npv);
      npv = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (pv) npv++;
         if (locked) break;
      end
      chk(nm, int'(locked), 1);
   endtask

   task automatic wait_fault(input int maxc, input string nm);
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (fault) break;
      end
      chk(nm, int'(fault), 1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_period"}, int'(period), 0);
      chk({nm, "_pv"}, int'(pv), 0);
      chk({nm, "_locked"}, int'(locked), 0);
      chk({nm, "_fault"}, int'(fault), 0);
   endtask

   int npv;
   int n6;
   bit sawlock;
   int r;

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst    = 1'b0;
      enable = 1'b1;

      wait_locked(100, "lock_div0", npv);
      chk("pv_to_lock", npv, 4);
      chk("period_div0", int'(period), 2);
      chk("fault_div0", int'(fault), 0);

      div_ctrl = 2'd3;
      wait_locked(300, "lock_div3", npv);
      chk("period_div3", int'(period), 16);

      div_ctrl = 2'd1;
      wait_locked(150, "lock_div1", npv);
      @(negedge clk);
      div_ctrl = 2'd2;
      @(negedge clk);
      chk("chg_unlock", int'(locked), 0);
      chk("chg_nofault", int'(fault), 0);
      wait_locked(200, "lock_div2", npv);
      chk("period_div2", int'(period), 8);

      div_ctrl = 2'd1;
      wait_locked(150, "lock_div1b", npv);
      gmode = 2;
      wait_fault(60, "stop_fault");
      chk("stop_unlock", int'(locked), 0);
      gmode     = 0;
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("clr_fault", int'(fault), 0);
      wait_locked(150, "relock_clr", npv);

      enable = 1'b0;
      gmode  = 1;
      ghalf  = 3;
      @(negedge clk);
      chk_zero("idle");
      enable  = 1'b1;
      n6      = 0;
      sawlock = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (i > 20 && pv) begin
            n6++;
            chk("period6", int'(period), 6);
         end
         if (locked) sawlock = 1'b1;
      end
      chk("p6_nolock", int'(sawlock), 0);
      chk("p6_pulses", int'(n6 >= 10), 1);

      gmode = 0;
      wait_locked(150, "lock_pre_rst", npv);
      gmode = 2;
      wait_fault(60, "fault_pre_rst");
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      gmode = 0;
      wait_locked(150, "relock_rst", npv);

      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         r = $urandom_range(0, 999);
         fault_clr = 1'b0;
         if (!enable && r > 900) enable = 1'b1;
         if (r < 8) begin
            div_ctrl = DW'($urandom_range(0, 3));
         end else if (r < 14) begin
            gmode = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
            ghalf = $urandom_range(1, 9);
         end else if (r < 30) begin
            fault_clr = 1'b1;
         end else if (r < 33) begin
            enable = 1'b0;
         end else if (r < 35) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      fault_clr = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
